// File: rtl/mem_access_unit.sv
// Load/store unit with a small internal data memory and a branch decision register.
// Loads run through an IDLE/BUSY/DONE sequencer with a fixed latency; stores finish in one cycle.
module mem_access_unit #(
   parameter int MEM_WORDS = 256,
   parameter int LOAD_LAT  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ALUResultIn,
   input  logic [31:0] MemDataIn,
   input  logic        MemReadIn,
   input  logic        MemWriteIn,
   input  logic [1:0]  dataTypeIn,
   input  logic [1:0]  BranchIn,
   input  logic        ZeroIn,
   input  logic [31:0] BranchAddResultIn,
   output logic [31:0] ReadDataOut,
   output logic        ReadValidOut,
   output logic        StallOut,
   output logic        MisalignOut,
   output logic        PCSrcOut,
   output logic [31:0] BranchTargetOut
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LOAD_LAT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state;
   logic [3:0]     cnt;
   logic [AW-1:0]  ld_idx;
   logic [1:0]     ld_off;
   logic [1:0]     ld_type;
   logic [31:0]    mem [MEM_WORDS];

   logic [AW-1:0]  idx;
   logic           misalign;
   logic           do_store;
   logic           do_load;
   logic [3:0]     be;
   logic [31:0]    wdata;
   logic           unused_addr;

   assign idx         = ALUResultIn[AW+1:2];
   assign unused_addr = ^ALUResultIn[31:AW+2];

   assign misalign = ((dataTypeIn == 2'b00) && (ALUResultIn[1:0] != 2'b00)) ||
                     ((dataTypeIn == 2'b01) && ALUResultIn[0]);

   // A write wins over a simultaneous read; the read is dropped entirely.
   assign do_store = rst_n && (state == IDLE) && MemWriteIn && !misalign;
   assign do_load  = rst_n && (state == IDLE) && MemReadIn && !MemWriteIn && !misalign;
   assign StallOut = do_load || (rst_n && (state == BUSY));

   always_comb begin
      be    = 4'b0000;
      wdata = MemDataIn;
      case (dataTypeIn)
         2'b00: be = 4'b1111;
         2'b01: begin
            be    = ALUResultIn[1] ? 4'b1100 : 4'b0011;
            wdata = {2{MemDataIn[15:0]}};
         end
         default: begin
            be    = 4'b0001 << ALUResultIn[1:0];
            wdata = {4{MemDataIn[7:0]}};
         end
      endcase
   end

   function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] typ);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (typ)
         2'b00:   extend = w;
         2'b01:   extend = {{16{sh[15]}}, sh[15:0]};
         2'b10:   extend = {{24{sh[7]}}, sh[7:0]};
         default: extend = {24'h0, sh[7:0]};
      endcase
   endfunction

   // Memory has no reset so its contents survive a mid-load abort.
   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         ld_idx          <= '0;
         ld_off          <= 2'b00;
         ld_type         <= 2'b00;
         ReadDataOut     <= 32'h0;
         ReadValidOut    <= 1'b0;
         MisalignOut     <= 1'b0;
         PCSrcOut        <= 1'b0;
         BranchTargetOut <= 32'h0;
      end else begin
         ReadValidOut    <= 1'b0;
         MisalignOut     <= 1'b0;
         PCSrcOut        <= ((BranchIn == 2'b01) && ZeroIn) ||
                            ((BranchIn == 2'b10) && !ZeroIn) ||
                            (BranchIn == 2'b11);
         BranchTargetOut <= BranchAddResultIn;
         case (state)
            IDLE: begin
               MisalignOut <= (MemReadIn || MemWriteIn) && misalign;
               if (do_load) begin
                  ld_idx  <= idx;
                  ld_off  <= ALUResultIn[1:0];
                  ld_type <= dataTypeIn;
                  cnt     <= CNT_INIT;
                  if (LOAD_LAT == 1) begin
                     state        <= DONE;
                     ReadDataOut  <= extend(mem[idx], ALUResultIn[1:0], dataTypeIn);
                     ReadValidOut <= 1'b1;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (cnt <= 4'd1) begin
                  cnt          <= 4'd0;
                  state        <= DONE;
                  ReadDataOut  <= extend(mem[ld_idx], ld_off, ld_type);
                  ReadValidOut <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected load results are queued at issue
// and compared by a monitor whenever ReadValidOut pulses.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ALUResultIn, MemDataIn, BranchAddResultIn;
   logic        MemReadIn, MemWriteIn, ZeroIn;
   logic [1:0]  dataTypeIn, BranchIn;
   logic [31:0] ReadDataOut, BranchTargetOut;
   logic        ReadValidOut, StallOut, MisalignOut, PCSrcOut;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   mem_access_unit #(.MEM_WORDS(256), .LOAD_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ALUResultIn(ALUResultIn), .MemDataIn(MemDataIn),
      .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .dataTypeIn(dataTypeIn),
      .BranchIn(BranchIn), .ZeroIn(ZeroIn), .BranchAddResultIn(BranchAddResultIn),
      .ReadDataOut(ReadDataOut), .ReadValidOut(ReadValidOut), .StallOut(StallOut),
      .MisalignOut(MisalignOut), .PCSrcOut(PCSrcOut), .BranchTargetOut(BranchTargetOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ReadValidOut === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            chk("load_data", ReadDataOut, exp_q.pop_front());
         end
      end
   end

   task automatic idle_in();
      MemReadIn = 1'b0; MemWriteIn = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
      ALUResultIn = a; MemDataIn = d; dataTypeIn = t; MemWriteIn = 1'b1;
      #1 chk("store_no_stall", StallOut, 0);
      @(posedge clk); #1;
      idle_in();
   endtask

   task automatic do_load(input logic [31:0] a, input logic [1:0] t, input logic [31:0] exp,
                          input string tag);
      ALUResultIn = a; dataTypeIn = t; MemReadIn = 1'b1;
      #1 chk({tag, "_stall_req"}, StallOut, 1);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      idle_in();
      chk({tag, "_stall_busy"}, StallOut, 1);
      chk({tag, "_valid_early"}, ReadValidOut, 0);
      @(posedge clk); #1;
      chk({tag, "_valid_lat"}, ReadValidOut, 1);
      chk({tag, "_stall_done"}, StallOut, 0);
      @(posedge clk); #1;
      chk({tag, "_valid_once"}, ReadValidOut, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  br_tbl;
      logic [31:0] tgt;
      br_tbl = 8'b1101_1000;
      rst_n = 1'b0; idle_in();
      ALUResultIn = 0; MemDataIn = 0; dataTypeIn = 0;
      BranchIn = 0; ZeroIn = 0; BranchAddResultIn = 32'h0000_1234;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_rdata", ReadDataOut, 0);
      chk("rst_valid", ReadValidOut, 0);
      chk("rst_stall", StallOut, 0);
      chk("rst_mis", MisalignOut, 0);
      chk("rst_pcsrc", PCSrcOut, 0);
      chk("rst_btgt", BranchTargetOut, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // word store then word load
      do_store(32'h10, 32'hDEADBEEF, 2'b00);
      do_load(32'h10, 2'b00, 32'hDEADBEEF, "ld_word");

      // byte store and sign/zero-extended byte loads
      do_store(32'h13, 32'h1234_5680, 2'b10);
      do_load(32'h13, 2'b10, 32'hFFFFFF80, "ld_b_sx");
      do_load(32'h13, 2'b11, 32'h00000080, "ld_b_zx");
      do_load(32'h10, 2'b00, 32'h80ADBEEF, "ld_word_merge");

      // half stores and loads at both halves
      do_store(32'h12, 32'hFFFF_A55A, 2'b01);
      do_load(32'h12, 2'b01, 32'hFFFFA55A, "ld_h_hi");
      do_load(32'h11, 2'b10, 32'hFFFFFFBE, "ld_b1_sx");
      do_load(32'h11, 2'b11, 32'h000000BE, "ld_b1_zx");
      do_store(32'h10, 32'h7777_1234, 2'b01);
      do_load(32'h10, 2'b01, 32'h00001234, "ld_h_lo_pos");
      do_load(32'h13, 2'b10, 32'hFFFFFFA5, "ld_b3_sx");

      // misaligned half load: dropped, single misalign pulse
      ALUResultIn = 32'h11; dataTypeIn = 2'b01; MemReadIn = 1'b1;
      #1 chk("mis_ld_no_stall", StallOut, 0);
      @(posedge clk); #1;
      idle_in();
      chk("mis_ld_pulse", MisalignOut, 1);
      chk("mis_ld_stall", StallOut, 0);
      @(posedge clk); #1;
      chk("mis_ld_pulse_end", MisalignOut, 0);
      chk("mis_ld_no_valid", ReadValidOut, 0);

      // misaligned word store: dropped, memory unchanged
      ALUResultIn = 32'h12; dataTypeIn = 2'b00; MemDataIn = 32'h0; MemWriteIn = 1'b1;
      @(posedge clk); #1;
      idle_in();
      chk("mis_st_pulse", MisalignOut, 1);
      @(posedge clk); #1;
      chk("mis_st_pulse_end", MisalignOut, 0);
      do_load(32'h10, 2'b00, 32'hA55A1234, "ld_after_mis");

      // reset during BUSY aborts the load
      do_store(32'h20, 32'h11223344, 2'b00);
      BranchIn = 2'b11; BranchAddResultIn = 32'h0000_0F00;
      ALUResultIn = 32'h20; dataTypeIn = 2'b00; MemReadIn = 1'b1;
      @(posedge clk); #1;
      idle_in();
      chk("abort_busy_stall", StallOut, 1);
      chk("abort_pcsrc_pre", PCSrcOut, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_rdata", ReadDataOut, 0);
      chk("abort_valid", ReadValidOut, 0);
      chk("abort_stall", StallOut, 0);
      chk("abort_mis", MisalignOut, 0);
      chk("abort_pcsrc", PCSrcOut, 0);
      chk("abort_btgt", BranchTargetOut, 0);
      BranchIn = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_valid", ReadValidOut, 0);
      end
      do_load(32'h20, 2'b00, 32'h11223344, "ld_after_abort");

      // address wrap-around and read+write collision
      do_store(32'h400, 32'hCAFEF00D, 2'b00);
      do_load(32'h0, 2'b00, 32'hCAFEF00D, "ld_alias");
      do_load(32'h403, 2'b11, 32'h000000CA, "ld_alias_b3");
      ALUResultIn = 32'h400; MemDataIn = 32'h0BADC0DE; dataTypeIn = 2'b00;
      MemReadIn = 1'b1; MemWriteIn = 1'b1;
      #1 chk("rw_no_stall", StallOut, 0);
      @(posedge clk); #1;
      idle_in();
      chk("rw_stall_after", StallOut, 0);
      @(posedge clk); #1;
      chk("rw_no_valid", ReadValidOut, 0);
      do_load(32'h0, 2'b00, 32'h0BADC0DE, "ld_rw_data");

      // branch decision while a load is BUSY
      ALUResultIn = 32'h20; dataTypeIn = 2'b00; MemReadIn = 1'b1;
      exp_q.push_back(32'h11223344);
      @(posedge clk); #1;
      idle_in();
      BranchIn = 2'b10; ZeroIn = 1'b0; BranchAddResultIn = 32'h1000_0040;
      chk("br_busy_stall", StallOut, 1);
      @(posedge clk); #1;
      chk("br_pcsrc", PCSrcOut, 1);
      chk("br_tgt", BranchTargetOut, 32'h1000_0040);
      chk("br_valid", ReadValidOut, 1);

      // full branch truth table
      for (int i = 0; i < 8; i++) begin
         tgt = $urandom;
         BranchIn = 2'(i >> 1); ZeroIn = i[0]; BranchAddResultIn = tgt;
         @(posedge clk); #1;
         chk("br_tbl_pcsrc", PCSrcOut, br_tbl[i]);
         chk("br_tbl_tgt", BranchTargetOut, tgt);
      end
      BranchIn = 2'b00;

      repeat (3) @(posedge clk);
      #1 chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
